// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: IDLE->READ->EXEC->WB command sequencer driving a 32x32 register file.
// Define REG_OP_SEQ_ZERO_EN to make register 0 read as zero and drop writes to it.
module reg_op_sequencer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs,
  input  logic [ADDR_W-1:0] cmd_rt,
  input  logic [IMM_W-1:0]  cmd_imm,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              busy
);
`ifdef REG_OP_SEQ_ZERO_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
  state_t              state;
  logic [2:0]          op;
  logic [ADDR_W-1:0]   rd, rs, rt;
  logic [IMM_W-1:0]    imm;
  logic [DATA_W-1:0]   a, b, alu;
  always_comb
    alu = op == 3'd0 ? a + b :
          op == 3'd1 ? a - b :
          op == 3'd2 ? a & b :
          op == 3'd3 ? a | b :
          op == 3'd4 ? a ^ b :
          op == 3'd5 ? a << b[4:0] :
          op == 3'd6 ? a + {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm} :
                       {imm, {(DATA_W-IMM_W){1'b0}}};
  // Outputs are registered one state ahead so they are flop-driven in the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rf_raddr1 <= '0;
      rf_raddr2 <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      done      <= 1'b0;
      result    <= '0;
      op        <= '0;
      rd        <= '0;
      rs        <= '0;
      rt        <= '0;
      imm       <= '0;
      a         <= '0;
      b         <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          state     <= READ;
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
          op        <= cmd_op;
          rd        <= cmd_rd;
          rs        <= cmd_rs;
          rt        <= cmd_rt;
          imm       <= cmd_imm;
          rf_raddr1 <= cmd_rs;
          rf_raddr2 <= cmd_rt;
        end
        READ: begin
          state     <= EXEC;
          a         <= ZERO_EN && rs == '0 ? '0 : rf_rdata1;
          b         <= ZERO_EN && rt == '0 ? '0 : rf_rdata2;
          rf_raddr1 <= '0;
          rf_raddr2 <= '0;
        end
        EXEC: begin
          state    <= WB;
          result   <= alu;
          rf_we    <= !(ZERO_EN && rd == '0);
          rf_waddr <= rd;
          rf_wdata <= alu;
          done     <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          rf_we     <= 1'b0;
          rf_waddr  <= '0;
          rf_wdata  <= '0;
          done      <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reg_op_sequencer.sv
// tb_reg_op_sequencer: directed self-checking bench with a behavioural register file.
module tb_reg_op_sequencer;
  logic        clk = 0, rst = 1, cmd_valid = 0;
  logic        cmd_ready, rf_we, done, busy;
  logic [2:0]  cmd_op = 0;
  logic [4:0]  cmd_rd = 0, cmd_rs = 0, cmd_rt = 0;
  logic [15:0] cmd_imm = 0;
  logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [31:0] rf_rdata1, rf_rdata2, rf_wdata, result;
  logic [31:0] rf [32] = '{default: 32'h0};
  int checks = 0, errors = 0;

  reg_op_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_imm(cmd_imm),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .done(done), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];
  always @(posedge clk) if (rf_we) rf[rf_waddr] <= rf_wdata;

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready, busy, rf_we, done, result, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata} !== {1'b1, 3'b0, 32'h0, 15'h0, 32'h0})
      $display("FAIL reset: ready=%b busy=%b we=%b done=%b result=%h ra1=%0d ra2=%0d wa=%0d wd=%h, required ready=1 others 0",
               cmd_ready, busy, rf_we, done, result, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata);
    if ({cmd_ready, busy, rf_we, done, result, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata} !== {1'b1, 3'b0, 32'h0, 15'h0, 32'h0}) errors++;
    rst = 0;
  endtask

  task automatic run_cmd(input string name, input logic [2:0] op, input logic [4:0] rd, rs, rt,
                         input logic [15:0] imm, input logic [31:0] exp, input logic exp_we);
    cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_imm = imm; cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    checks++;
    if ({busy, cmd_ready, rf_we, done, rf_raddr1, rf_raddr2} !== {4'b1000, rs, rt}) begin
      errors++;
      $display("FAIL %s read: busy=%b ready=%b we=%b done=%b ra1=%0d ra2=%0d, required 1 0 0 0 %0d %0d",
               name, busy, cmd_ready, rf_we, done, rf_raddr1, rf_raddr2, rs, rt);
    end
    @(posedge clk); #1;
    checks++;
    if ({rf_we, done} !== 2'b00) begin
      errors++;
      $display("FAIL %s exec: we=%b done=%b, required 0 0", name, rf_we, done);
    end
    @(posedge clk); #1;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, done, result} !== {exp_we, rd, exp, 1'b1, exp}) begin
      errors++;
      $display("FAIL %s wb: we=%b wa=%0d wd=%h done=%b result=%h, required %b %0d %h 1 %h",
               name, rf_we, rf_waddr, rf_wdata, done, result, exp_we, rd, exp, exp);
    end
    @(posedge clk); #1;
    checks++;
    if ({rf_we, done, cmd_ready, busy, rf_waddr, rf_wdata, result} !== {4'b0010, 5'h0, 32'h0, exp} ||
        (exp_we && rf[rd] !== exp)) begin
      errors++;
      $display("FAIL %s idle: we=%b done=%b ready=%b busy=%b wa=%0d wd=%h result=%h r%0d=%h, required 0 0 1 0 0 0 %h %h",
               name, rf_we, done, cmd_ready, busy, rf_waddr, rf_wdata, result, rd, rf[rd], exp, exp);
    end
  endtask

  task automatic test_ops;
    run_cmd("lui",  3'd7, 5'd1, 5'd0, 5'd0, 16'h1234, 32'h12340000, 1'b1);
    run_cmd("addi", 3'd6, 5'd2, 5'd1, 5'd0, 16'hFFFF, 32'h1233FFFF, 1'b1);
    run_cmd("sub",  3'd1, 5'd3, 5'd0, 5'd1, 16'h0,    32'hEDCC0000, 1'b1);
    run_cmd("ld5",  3'd6, 5'd5, 5'd0, 5'd0, 16'h0024, 32'h00000024, 1'b1);
    run_cmd("sll",  3'd5, 5'd4, 5'd2, 5'd5, 16'h0,    32'h233FFFF0, 1'b1);
    run_cmd("add",  3'd0, 5'd20, 5'd1, 5'd2, 16'h0,   32'h2467FFFF, 1'b1);
    run_cmd("and",  3'd2, 5'd21, 5'd1, 5'd2, 16'h0,   32'h12300000, 1'b1);
    run_cmd("or",   3'd3, 5'd22, 5'd1, 5'd2, 16'h0,   32'h1237FFFF, 1'b1);
    run_cmd("xor",  3'd4, 5'd23, 5'd1, 5'd2, 16'h0,   32'h0007FFFF, 1'b1);
    run_cmd("self", 3'd0, 5'd5, 5'd5, 5'd5, 16'h0,    32'h00000048, 1'b1);
    run_cmd("ld6",  3'd6, 5'd6, 5'd0, 5'd0, 16'h05A5, 32'h000005A5, 1'b1);
  endtask

  task automatic test_back_to_back;
    int accepts = 0;
    logic rdy;
    cmd_valid = 1;
    for (int i = 0; i < 12; i++) begin
      cmd_op = 3'd6; cmd_rd = 5'(8 + i); cmd_rs = 5'd1; cmd_rt = 5'd0; cmd_imm = 16'(i);
      rdy = cmd_ready;
      if (rdy) accepts++;
      @(posedge clk); #1;
      if (rdy) begin
        checks++;
        if ({rf_we, busy} !== 2'b01) begin
          errors++;
          $display("FAIL b2b_read%0d: we=%b busy=%b, required 0 1", i, rf_we, busy);
        end
      end
    end
    cmd_valid = 0;
    checks++;
    if (accepts != 3) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d, required 3", accepts);
    end
    checks++;
    if ({rf[8], rf[12], rf[16], rf[9]} !== {32'h12340000, 32'h12340004, 32'h12340008, 32'h0}) begin
      errors++;
      $display("FAIL b2b_regs: r8=%h r12=%h r16=%h r9=%h, required 12340000 12340004 12340008 0",
               rf[8], rf[12], rf[16], rf[9]);
    end
  endtask

  task automatic test_reset_mid_op;
    cmd_op = 3'd0; cmd_rd = 5'd6; cmd_rs = 5'd1; cmd_rt = 5'd2; cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checks++;
    if ({rf_we, done, cmd_ready, busy, result} !== {4'b0010, 32'h0}) begin
      errors++;
      $display("FAIL rst_mid: we=%b done=%b ready=%b busy=%b result=%h, required 0 0 1 0 0",
               rf_we, done, cmd_ready, busy, result);
    end
    @(posedge clk); #1;
    checks++;
    if ({rf_we, done, rf[6]} !== {2'b00, 32'h000005A5}) begin
      errors++;
      $display("FAIL rst_after: we=%b done=%b r6=%h, required 0 0 000005a5", rf_we, done, rf[6]);
    end
  endtask

`ifdef REG_OP_SEQ_ZERO_EN
  task automatic test_zero_reg;
    run_cmd("addi_r0", 3'd6, 5'd0, 5'd0, 5'd0, 16'h0007, 32'h00000007, 1'b0);
    run_cmd("add_r7",  3'd0, 5'd7, 5'd0, 5'd0, 16'h0,    32'h00000000, 1'b1);
    checks++;
    if (rf[0] !== 32'h0) begin
      errors++;
      $display("FAIL zero_r0: r0=%h, required 0", rf[0]);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_ops;
    test_back_to_back;
    test_reset_mid_op;
`ifdef REG_OP_SEQ_ZERO_EN
    test_zero_reg;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_op_sequencer.md
# reg_op_sequencer

Multi-cycle command sequencer that sits directly upstream of the 32×32-bit register file and is its only driver. It accepts one register-to-register command per handshake and reads the two source registers through the file's two read ports. It computes a 32-bit result and writes it back through the file's single write port. It owns the write-enable timing, so source operands are always sampled in a cycle with the write port idle.

## Interface
- ADDR_W, 5, register address width (32 registers)
- DATA_W, 32, register data width
- IMM_W, 16, immediate field width
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  operation code
- cmd_rd / cmd_rs / cmd_rt  in  5 each  destination / source-1 / source-2 register
- cmd_imm  in  16  immediate
- rf_raddr1 / rf_raddr2  out  5 each  register file read addresses
- rf_rdata1 / rf_rdata2  in  32 each  register file read data
- rf_we  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  32  register file write data
- done  out  1  one-cycle pulse when the write-back cycle occurs
- result  out  32  last computed result, held until the next command completes
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE → READ → EXEC → WB → IDLE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch op/rd/rs/rt/imm and go to READ. Otherwise stay in IDLE.
- READ: rf_raddr1=rs, rf_raddr2=rt, rf_we=0. At the end of the cycle, register rf_rdata1/rf_rdata2 into the operand registers A/B.
- EXEC: compute from A, B and imm into the result register, per cmd_op:
  - 000 ADD: A+B
  - 001 SUB: A−B
  - 010 AND: A&B
  - 011 OR: A|B
  - 100 XOR: A^B
  - 101 SLL: A<<B[4:0]
  - 110 ADDI: A+sign-extended imm
  - 111 LUI: {imm,16'h0}
- Arithmetic is modulo 2^32. There is no carry or overflow output.
- WB: rf_we=1, rf_waddr=rd, rf_wdata=result, done=1 for exactly this cycle. Then go to IDLE.
- rf_we is high only in WB. In every other state, rf_we=0 and rf_waddr/rf_wdata=0.
- rd==rs or rd==rt is legal. Operands are captured in READ, before the WB edge.
- cmd_valid while busy is ignored. The upstream must hold the command until cmd_ready.
- Reset values: cmd_ready=1, busy=0, rf_we=0, done=0, result=0. All address and data outputs are 0. The FSM is in IDLE.
- Reset mid-operation: the next edge with rst=1 returns the FSM to IDLE. The in-flight command is dropped, with no write and no done pulse.

## Timing
- Handshake at edge E0. READ occupies cycle E0→E1, EXEC occupies E1→E2, WB occupies E2→E3. The register file updates at E3.
- cmd_ready rises again in the cycle after WB. Throughput is one command per 4 cycles.
- Back-to-back dependent commands need no forwarding. The next READ begins at least one cycle after the write edge.
- result updates at the end of EXEC and is stable from WB until the next command's EXEC.

## Configuration
- REG_OP_SEQ_ZERO_EN defined:
  - Register 0 reads as zero: the operand is forced to 0 when rs/rt==0.
  - Writes with rd==0 keep rf_we=0 in WB.
  - done and result still update as normal.
- REG_OP_SEQ_ZERO_EN undefined: register 0 behaves as an ordinary register.

## Test plan
- Reset, then LUI rd=1 imm=16'h1234 → WB cycle shows rf_we=1, rf_waddr=1, rf_wdata=32'h12340000; done pulses once, 3 cycles after the handshake.
- ADDI rd=2 rs=1 imm=16'hFFFF after the case above → r2=32'h1233FFFF (sign-extended −1).
- SUB rd=3 rs=0 rt=1 with r0=0 → r3=32'hEDCC0000 (wrap-around); SLL rd=4 rs=2 rt=5 with r5=32'h00000024 → shift by 4.
- cmd_valid held high continuously with changing fields → exactly one accept per 4 cycles, and rf_we is never high in a READ cycle.
- rst asserted during EXEC of ADD rd=6 → no rf_we, no done; r6 unchanged; cmd_ready=1 on the next cycle.
- With REG_OP_SEQ_ZERO_EN: ADDI rd=0 rs=0 imm=7 → done=1, result=7, rf_we stays 0; a subsequent ADD rd=7 rs=0 rt=0 gives r7=0.
